decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
//  Parametrised instruction-decode pipeline register (stage 1 -> stage 2).
//  Splits a 32-bit instruction into register addresses, write-select, extended immediate and ALU controls.
//  Adds a valid/ready handshake with a 2-entry skid buffer, flush, bubble/NOP detection and r0 write suppression.
//  Sits between instruction fetch and register-file read / ALU stage.
// PARAMETERS
//  DATA_W    32  width of extended immediate S1_IMM (>=16)
//  SIGN_EXT  1   1: sign-extend InstrIn[15:0]; 0: zero-extend
//  CNT_W     16  width of perf counters (macro-gated)
// PORTS
//  clk            in   1       clock, all logic on posedge
//  reset          in   1       synchronous, active-high
//  flush          in   1       discard all held and in-flight instructions
//  in_valid       in   1       InstrIn valid
//  in_ready       out  1       stage can accept InstrIn
//  InstrIn        in   32      instruction word
//  out_valid      out  1       decoded fields valid
//  out_ready      in   1       downstream accepts decoded fields
//  S1_RD1         out  5       read addr 1 = InstrIn[20:16]
//  S1_RD2         out  5       read addr 2 = InstrIn[15:11]
//  S1_WS          out  5       write select = InstrIn[25:21]
//  S1_IMM         out  DATA_W  InstrIn[15:0] extended per SIGN_EXT
//  S1_DataSource  out  1       InstrIn[29] (1 = immediate operand)
//  S1_ALUOP       out  3       InstrIn[28:26]
//  S1_WE          out  1       register write enable
// BEHAVIOUR
//  - Reset: all outputs 0, including in_ready, out_valid, S1_WE and every field; both buffer entries empty.
//  - in_ready rises the cycle after reset deasserts.
//  - Transfers: input when in_valid & in_ready; output when out_valid & out_ready.
//  - Latency: instruction accepted at edge N appears on outputs after edge N (1 cycle); all outputs registered.
//  - Storage: main entry drives outputs; skid entry holds one extra instruction.
//    - Output stall with main full and a new input accepted: the new input goes to skid.
//    - in_ready = !skid_full (registered); at most 2 held.
//  - Drain: when output transfers and skid full, skid moves to main at the next edge and skid clears.
//    - Accept + output transfer in the same cycle with skid empty: main reloads directly, no bubble.
//  - Order is strictly FIFO; no instruction is duplicated or dropped except by flush/reset.
//  - S1_WE = 0 if InstrIn == 32'h0 (NOP/bubble) or InstrIn[25:21] == 0 (r0 write); else 1.
//    - NOP still occupies a slot and produces out_valid.
//  - Fields are computed at capture time and stored decoded.
//    - Field outputs hold their last value while out_valid = 0.
//    - S1_WE is forced 0 whenever out_valid = 0.
//  - Flush (priority over everything but reset):
//    - next cycle out_valid = 0, S1_WE = 0, both entries empty, in_ready = 1;
//    - an input presented during the flush cycle is discarded.
//  - Reset mid-stream: identical to flush, plus every field is cleared to 0.
//  - out_ready while out_valid = 0 is ignored.
//  - in_valid while in_ready = 0: no capture; the source must hold InstrIn.
// CONFIGURATION
//  DECODE_PERF_CNT_EN defined:
//    - adds outputs perf_issued [CNT_W] (output transfers) and perf_stall [CNT_W] (cycles with out_valid & !out_ready);
//    - both counters saturate at all-ones, clear on reset, and do not clear on flush.
//  DECODE_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. Decode, SIGN_EXT=1: InstrIn=32'h2C22_8005, out_ready=1 ->
//     next cycle RD1=2, RD2=16, WS=1, IMM=32'hFFFF_8005, DataSource=1, ALUOP=3'b011, WE=1.
//  2. Same word with SIGN_EXT=0 -> IMM=32'h0000_8005. InstrIn=32'h0 -> out_valid=1, WE=0.
//     WS=0 word 32'h2C02_0001 -> WE=0.
//  3. Backpressure: stream A,B,C back-to-back with out_ready=0 ->
//     A on outputs, B in skid, in_ready=0, C held by source.
//     Then out_ready=1 -> outputs A,B,C on consecutive cycles.
//  4. Full throughput: 8 instructions, in_valid=out_ready=1 every cycle -> 8 outputs in 8 consecutive cycles, in_ready stays 1.
//  5. Flush with 2 held plus in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the 3 instructions emerge.
//  6. Reset asserted with 2 held -> all outputs 0 next cycle.
//     With DECODE_PERF_CNT_EN: perf_stall counts 5 after 5 stalled cycles; perf_issued=0 after reset.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode pipeline register: splits a 32-bit instruction into decoded fields, 2-entry skid buffer.
// Latency: 1 cycle from input acceptance to registered outputs; full throughput with out_ready held high.
// Backpressure: in_ready (registered) drops while the skid entry is occupied; flush empties both entries.
//
// Ports: clk/reset (sync, active-high), flush, in_valid/in_ready/InstrIn (upstream handshake),
//        out_valid/out_ready (downstream handshake), S1_* decoded fields.
// Optional feature: define DECODE_PERF_CNT_EN to add saturating perf_issued / perf_stall counters.
module decode_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter bit SIGN_EXT = 1'b1
`ifdef DECODE_PERF_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       InstrIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        S1_RD1,
    output logic [4:0]        S1_RD2,
    output logic [4:0]        S1_WS,
    output logic [DATA_W-1:0] S1_IMM,
    output logic              S1_DataSource,
    output logic [2:0]        S1_ALUOP,
    output logic              S1_WE
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_issued,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    typedef struct packed {
        logic [4:0]        rd1;
        logic [4:0]        rd2;
        logic [4:0]        ws;
        logic [DATA_W-1:0] imm;
        logic              ds;
        logic [2:0]        aluop;
        logic              we;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.rd1   = w[20:16];
        d.rd2   = w[15:11];
        d.ws    = w[25:21];
        d.imm   = SIGN_EXT ? DATA_W'($signed(w[15:0])) : DATA_W'(w[15:0]);
        d.ds    = w[29];
        d.aluop = w[28:26];
        // All-zero word is a bubble; writes to r0 are suppressed.
        d.we    = (w != 32'h0) && (w[25:21] != 5'd0);
        return d;
    endfunction

    // Opcode bits [31:30] carry nothing this stage decodes.
    logic unused_opc;
    assign unused_opc = ^InstrIn[31:30];

    dec_t main_q, main_d;
    dec_t skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic in_ready_q, in_ready_d;

    dec_t dec_in;
    logic acc;
    logic deq;

    assign dec_in = decode(InstrIn);
    assign acc    = in_valid && in_ready_q;
    assign deq    = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            // Fields hold their last value; only valid and write-enable drop.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_d.we  = 1'b0;
        end else if (deq) begin
            if (skid_vld_q) begin
                // in_ready is low while skid is full, so no accept can coincide.
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (acc) begin
                main_d     = dec_in;
            end else begin
                main_vld_d = 1'b0;
                main_d.we  = 1'b0;
            end
        end else if (!main_vld_q) begin
            if (acc) begin
                main_d     = dec_in;
                main_vld_d = 1'b1;
            end
        end else if (acc) begin
            // Output stalled with main occupied: park the new word in skid.
            skid_d     = dec_in;
            skid_vld_d = 1'b1;
        end
        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_vld_q;
    assign S1_RD1        = main_q.rd1;
    assign S1_RD2        = main_q.rd2;
    assign S1_WS         = main_q.ws;
    assign S1_IMM        = main_q.imm;
    assign S1_DataSource = main_q.ds;
    assign S1_ALUOP      = main_q.aluop;
    // we is cleared in main_q whenever main empties, so this stays a register output.
    assign S1_WE         = main_q.we;

`ifdef DECODE_PERF_CNT_EN
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] stall_q,  stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (deq && (issued_q != '1)) issued_d = issued_q + 1'b1;
        if (main_vld_q && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

    localparam int DATA_W   = 32;
    localparam bit SIGN_EXT = 1'b1;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] InstrIn;
    logic        in_ready, out_valid;
    logic [4:0]  S1_RD1, S1_RD2, S1_WS;
    logic [DATA_W-1:0] S1_IMM;
    logic        S1_DataSource, S1_WE;
    logic [2:0]  S1_ALUOP;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] perf_issued, perf_stall;
    int unsigned m_issued, m_stall;
`endif

    always #5 clk = ~clk;

    decode_stage_pipe #(.DATA_W(DATA_W), .SIGN_EXT(SIGN_EXT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .InstrIn(InstrIn),
        .out_valid(out_valid), .out_ready(out_ready),
        .S1_RD1(S1_RD1), .S1_RD2(S1_RD2), .S1_WS(S1_WS), .S1_IMM(S1_IMM),
        .S1_DataSource(S1_DataSource), .S1_ALUOP(S1_ALUOP), .S1_WE(S1_WE)
`ifdef DECODE_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    // Reference model: a FIFO of held instruction words plus the last word shown on the outputs.
    logic [31:0] q[$];
    logic [31:0] m_word = 32'h0;
    bit          m_rdy  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        logic [31:0] lo;
        lo = w & 32'h0000_FFFF;
        if (SIGN_EXT && lo >= 32'd32768) return lo + 32'hFFFF_0000;
        return lo;
    endfunction

    function automatic bit m_we(input logic [31:0] w);
        return (w != 0) && (((w >> 21) & 32'd31) != 0);
    endfunction

    task automatic compare_all();
        bit vld;
        vld = q.size() > 0;
        check("out_valid", 64'(out_valid), 64'(vld));
        check("in_ready",  64'(in_ready),  64'(m_rdy));
        check("RD1",  64'(S1_RD1), 64'((m_word >> 16) & 32'd31));
        check("RD2",  64'(S1_RD2), 64'((m_word >> 11) & 32'd31));
        check("WS",   64'(S1_WS),  64'((m_word >> 21) & 32'd31));
        check("IMM",  64'(S1_IMM), 64'(m_imm(m_word)));
        check("DS",   64'(S1_DataSource), 64'((m_word >> 29) & 32'd1));
        check("ALUOP",64'(S1_ALUOP), 64'((m_word >> 26) & 32'd7));
        check("WE",   64'(S1_WE), 64'(vld && m_we(m_word)));
`ifdef DECODE_PERF_CNT_EN
        check("perf_issued", 64'(perf_issued), 64'(m_issued));
        check("perf_stall",  64'(perf_stall),  64'(m_stall));
`endif
    endtask

    // Advance one clock, update the model with the inputs present at the edge, then compare.
    task automatic cycle();
        bit acc, deq, vld;
        vld = q.size() > 0;
        acc = in_valid && m_rdy;
        deq = vld && out_ready;
        @(posedge clk);
`ifdef DECODE_PERF_CNT_EN
        if (reset) begin
            m_issued = 0; m_stall = 0;
        end else begin
            if (deq && m_issued < 16'hFFFF) m_issued++;
            if (vld && !out_ready && m_stall < 16'hFFFF) m_stall++;
        end
`endif
        if (reset) begin
            q.delete(); m_word = 32'h0; m_rdy = 1'b0;
        end else if (flush) begin
            q.delete(); m_rdy = 1'b1;
        end else begin
            if (deq) begin
                void'(q.pop_front());
                n_out++;
            end
            if (acc) q.push_back(InstrIn);
            if (q.size() > 0) m_word = q[0];
            m_rdy = q.size() < 2;
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input bit iv, input logic [31:0] w, input bit ordy);
        in_valid = iv; InstrIn = w; out_ready = ordy;
    endtask

    initial begin
        bit hold;
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        cycle(); cycle();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready),  64'd0);
        check("rst_imm",   64'(S1_IMM),    64'd0);
        reset = 1'b0;
        cycle();
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Directed decode of a known word.
        drive(1'b1, 32'h2C22_8005, 1'b1);
        cycle();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_rd1",   64'(S1_RD1), 64'd2);
        check("t1_rd2",   64'(S1_RD2), 64'd16);
        check("t1_ws",    64'(S1_WS),  64'd1);
        check("t1_imm",   64'(S1_IMM), 64'hFFFF_8005);
        check("t1_ds",    64'(S1_DataSource), 64'd1);
        check("t1_alu",   64'(S1_ALUOP), 64'd3);
        check("t1_we",    64'(S1_WE), 64'd1);
        drive(1'b1, 32'h0, 1'b1);
        cycle();
        check("nop_valid", 64'(out_valid), 64'd1);
        check("nop_we",    64'(S1_WE), 64'd0);
        drive(1'b1, 32'h2C02_0001, 1'b1);
        cycle();
        check("r0_we", 64'(S1_WE), 64'd0);
        drive(1'b0, 32'h0, 1'b1);
        cycle();

        // Backpressure: A, B, C with the output stalled.
        drive(1'b1, 32'h0441_0001, 1'b0); cycle();
        drive(1'b1, 32'h0882_0002, 1'b0); cycle();
        drive(1'b1, 32'h0CC3_0003, 1'b0); cycle();
        check("bp_ready", 64'(in_ready), 64'd0);
        check("bp_head",  64'(S1_WS), 64'd2);
        out_ready = 1'b1;
        cycle(); check("bp_B", 64'(S1_WS), 64'd4);
        cycle(); check("bp_C", 64'(S1_WS), 64'd6);
        drive(1'b0, 32'h0, 1'b1);
        cycle(); check("bp_empty", 64'(out_valid), 64'd0);

        // Full throughput.
        n_out = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h2000_0000 | (32'(i + 1) << 21) | 32'(i), 1'b1);
            cycle();
            check("thru_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, 32'h0, 1'b1);
        cycle();
        check("thru_count", 64'(n_out), 64'd8);

        // Flush with two held and a third presented.
        drive(1'b1, 32'h0441_1111, 1'b0); cycle();
        drive(1'b1, 32'h0882_2222, 1'b0); cycle();
        flush = 1'b1; drive(1'b1, 32'h0CC3_3333, 1'b0);
        cycle();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        drive(1'b0, 32'h0, 1'b1);
        cycle(); cycle();
        check("fl_gone", 64'(out_valid), 64'd0);

        // Reset with two held.
        drive(1'b1, 32'hFFFF_FFFF, 1'b0); cycle();
        drive(1'b1, 32'h2C22_8005, 1'b0); cycle();
        reset = 1'b1; drive(1'b0, 32'h0, 1'b0);
        cycle();
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_ws",    64'(S1_WS),     64'd0);
        check("mrst_imm",   64'(S1_IMM),    64'd0);
        reset = 1'b0;
        cycle();

        // Randomised traffic; a stalled source holds its word.
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit was_acc;
            logic [31:0] w;
            reset     = ($urandom % 250) == 0;
            flush     = ($urandom % 40) == 0;
            out_ready = ($urandom % 4) != 0;
            if (!hold) begin
                w = $urandom;
                case ($urandom % 8)
                    0: w = 32'h0;
                    1: w = w & ~32'h03E0_0000;
                    default: ;
                endcase
                InstrIn  = w;
                in_valid = ($urandom % 3) != 0;
            end
            was_acc = in_valid && m_rdy;
            cycle();
            hold = in_valid && !was_acc;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
